multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle control unit that sequences the CPU datapath around the program counter. Walks each instruction through IF/ID/EXE/MEM/WB states and issues one-cycle write strobes for the PC, IR, register file and data memory. Selects the next-PC source at the retire cycle of every instruction and counts retired instructions. Sits between the instruction register's opcode field and the PC, IR, register file, ALU flags and data memory.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- CLK  in  1  clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high; sampled on rising edge of CLK
- opcode  in  6  IR[31:26]; valid from ID onward, held stable by the IR until the next IF
- zero  in  1  ALU zero flag; valid in EXE
- PCWre  out  1  PC load enable; one-cycle pulse at instruction retire
- PCSrc  out  2  next-PC select: 00 PC+4, 01 branch target, 10 jr register, 11 jump target; meaningful only while PCWre=1, else 00
- IRWre  out  1  IR load enable; high in IF
- RegWre  out  1  register-file write enable
- RegDst  out  2  write-address select: 00 rt, 01 rd, 10 $31
- MemRd  out  1  data-memory read strobe
- MemWr  out  1  data-memory write strobe
- state  out  3  current state: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=101
- instr_cnt  out  CNT_W  retired-instruction count

## Operation
- Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, slt 100110, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, jr 111001, jal 111010, halt 111111.
- ALU group (add, sub, addi, or, and, ori, slt): IF→ID→EXE→WB→IF. RegWre=1 in WB. RegDst=01 for R-type (add, sub, or, and, slt), 00 for the immediate forms.
- lw: IF→ID→EXE→MEM→WB→IF. MemRd=1 in MEM. RegWre=1 and RegDst=00 in WB.
- sw: IF→ID→EXE→MEM→IF. MemWr=1 in MEM.
- beq/bne: IF→ID→EXE→IF. In EXE, PCSrc=01 if (beq and zero) or (bne and !zero), else 00.
- j: IF→ID→IF with PCSrc=11.
- jr: IF→ID→IF with PCSrc=10.
- jal: IF→ID→IF with PCSrc=11, plus RegWre=1 and RegDst=10 in ID.
- halt: IF→ID→HALT. HALT is absorbing: PCWre=0, no strobes, instr_cnt frozen. Exit only via Reset.
- Unknown opcode: treated as a nop, IF→ID→IF with PCSrc=00.
- PCWre=1 exactly in the final state of each instruction: WB for ALU and lw, MEM for sw, EXE for branches, ID for jumps and nops. Never asserted in IF or HALT.
- instr_cnt increments by 1 at the rising edge ending every PCWre=1 cycle. It wraps modulo 2^CNT_W.
- Strobes are decoded combinationally from the state register and opcode. At most one of MemRd/MemWr is high in any cycle.

## Timing
- Reset=1 at a rising edge: state←IF, instr_cnt←0. This applies from any state, mid-instruction and in HALT. While Reset is high, all strobes (PCWre, IRWre, RegWre, MemRd, MemWr) are forced 0, and PCSrc and RegDst are 00.
- The first cycle after Reset deasserts is IF with IRWre=1.
- CPI: ALU 4, lw 5, sw 4, beq/bne 3, j/jr/jal/nop 2. Halt takes 2 cycles to reach HALT.
- The PC and IR update at the edge ending their enable cycle. The opcode for the next instruction is therefore valid in the ID cycle that follows.
- zero is sampled combinationally during EXE only. Changes in other states are ignored.

## Test plan
- Reset, then an add: states 000,001,010,100,000. IRWre=1 in cycle 0, RegWre=1/RegDst=01/PCWre=1/PCSrc=00 in cycle 3. instr_cnt 0→1.
- lw then sw: lw gives MemRd=1 in MEM and RegWre=1 in WB, retiring after 5 cycles. sw gives MemWr=1 with PCWre=1 in MEM, retiring after 4 cycles. instr_cnt=2.
- beq with zero=1 → PCSrc=01 at the EXE cycle. beq with zero=0 → 00. bne with zero=0 → 01. Each retires in 3 cycles.
- jal → in ID: PCWre=1, PCSrc=11, RegWre=1, RegDst=10. jr → PCSrc=10. Opcode 101010 → nop with PCSrc=00, 2 cycles.
- halt → state 101 held for 20 cycles, PCWre=0 throughout, instr_cnt unchanged. Reset=1 → next state 000 and instr_cnt=0.
- Reset asserted during the MEM cycle of lw → same-cycle strobes forced 0, then IF next and no RegWre. Also preload instr_cnt to 2^CNT_W−1 (via CNT_W=4 and 15 retires), then one more retire → wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
//  Module   : multicycle_ctrl_if
//  Purpose  : Control-unit <-> datapath signal bundle (opcode/flags in, strobes out)
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             zero;
    logic             PCWre;
    logic [1:0]       PCSrc;
    logic             IRWre;
    logic             RegWre;
    logic [1:0]       RegDst;
    logic             MemRd;
    logic             MemWr;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_cnt;

    // master = control unit, slave = datapath side
    modport master (
        input  opcode, zero,
        output PCWre, PCSrc, IRWre, RegWre, RegDst, MemRd, MemWr, state, instr_cnt
    );

    modport slave (
        output opcode, zero,
        input  PCWre, PCSrc, IRWre, RegWre, RegDst, MemRd, MemWr, state, instr_cnt
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Multi-cycle IF/ID/EXE/MEM/WB sequencer with PC-source select
//             and retired-instruction counter
//  Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  wire logic        CLK,
    input  wire logic        Reset,
    multicycle_ctrl_if.master bus
);
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101
    } state_t;

    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] cnt;

    logic is_rtype, is_itype, is_lw, is_sw, is_beq, is_bne;
    logic is_j, is_jr, is_jal, is_halt;
    logic is_alu, is_branch, br_taken;

    logic       pcwre, irwre, regwre, memrd, memwr;
    logic [1:0] pcsrc, regdst;

    always_comb begin
        is_rtype = 1'b0;
        is_itype = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        is_jr    = 1'b0;
        is_jal   = 1'b0;
        is_halt  = 1'b0;
        case (bus.opcode)
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLT: is_rtype = 1'b1;
            OP_ADDI, OP_ORI:                       is_itype = 1'b1;
            OP_LW:                                 is_lw    = 1'b1;
            OP_SW:                                 is_sw    = 1'b1;
            OP_BEQ:                                is_beq   = 1'b1;
            OP_BNE:                                is_bne   = 1'b1;
            OP_J:                                  is_j     = 1'b1;
            OP_JR:                                 is_jr    = 1'b1;
            OP_JAL:                                is_jal   = 1'b1;
            OP_HALT:                               is_halt  = 1'b1;
            default: ;
        endcase
    end

    assign is_alu    = is_rtype | is_itype;
    assign is_branch = is_beq | is_bne;
    assign br_taken  = (is_beq & bus.zero) | (is_bne & ~bus.zero);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cur_state <= S_IF;
            cnt       <= '0;
        end else begin
            cur_state <= nxt_state;
            if (pcwre) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        nxt_state = cur_state;
        pcwre     = 1'b0;
        pcsrc     = 2'b00;
        irwre     = 1'b0;
        regwre    = 1'b0;
        regdst    = 2'b00;
        memrd     = 1'b0;
        memwr     = 1'b0;
        case (cur_state)
            S_IF: begin
                irwre     = 1'b1;
                nxt_state = S_ID;
            end
            S_ID: begin
                if (is_halt) begin
                    nxt_state = S_HALT;
                end else if (is_alu | is_lw | is_sw | is_branch) begin
                    nxt_state = S_EXE;
                end else begin
                    // jumps and unknown opcodes (nop) retire here
                    pcwre     = 1'b1;
                    nxt_state = S_IF;
                    if (is_jr) begin
                        pcsrc = 2'b10;
                    end else if (is_j | is_jal) begin
                        pcsrc = 2'b11;
                    end
                    if (is_jal) begin
                        regwre = 1'b1;
                        regdst = 2'b10;
                    end
                end
            end
            S_EXE: begin
                if (is_alu) begin
                    nxt_state = S_WB;
                end else if (is_lw | is_sw) begin
                    nxt_state = S_MEM;
                end else begin
                    pcwre     = 1'b1;
                    pcsrc     = br_taken ? 2'b01 : 2'b00;
                    nxt_state = S_IF;
                end
            end
            S_MEM: begin
                if (is_lw) begin
                    memrd     = 1'b1;
                    nxt_state = S_WB;
                end else begin
                    memwr     = 1'b1;
                    pcwre     = 1'b1;
                    nxt_state = S_IF;
                end
            end
            S_WB: begin
                regwre    = 1'b1;
                regdst    = is_rtype ? 2'b01 : 2'b00;
                pcwre     = 1'b1;
                nxt_state = S_IF;
            end
            S_HALT: nxt_state = S_HALT;
            default: nxt_state = S_IF;
        endcase

        // Reset silences every strobe in the same cycle, whatever the state
        if (Reset) begin
            pcwre  = 1'b0;
            pcsrc  = 2'b00;
            irwre  = 1'b0;
            regwre = 1'b0;
            regdst = 2'b00;
            memrd  = 1'b0;
            memwr  = 1'b0;
        end
    end

    assign bus.PCWre     = pcwre;
    assign bus.PCSrc     = pcsrc;
    assign bus.IRWre     = irwre;
    assign bus.RegWre    = regwre;
    assign bus.RegDst    = regdst;
    assign bus.MemRd     = memrd;
    assign bus.MemWr     = memwr;
    assign bus.state     = cur_state;
    assign bus.instr_cnt = cnt;

endmodule

`default_nettype wire
